// File: rtl/valu_mac_lane_if.sv
// Operand/result handshake bundle for one vector-lane MAC ALU.
// slave = lane side, master = producer/consumer side.
interface valu_mac_lane_if #(
  parameter int vdw_p      = 32,
  parameter int op_width_p = 2
);
  logic                  v_i;
  logic                  ready_o;
  logic [vdw_p-1:0]      a_i;
  logic [vdw_p-1:0]      b_i;
  logic [op_width_p-1:0] op_i;
  logic                  clear_acc_i;
  logic                  v_o;
  logic                  yumi_i;
  logic [vdw_p-1:0]      result_o;
  logic                  flag_overflow_o;
  logic                  flag_zero_o;
  logic                  flag_negative_o;
  logic [vdw_p-1:0]      acc_o;

  modport slave (
    input  v_i, a_i, b_i, op_i, clear_acc_i, yumi_i,
    output ready_o, v_o, result_o, flag_overflow_o, flag_zero_o, flag_negative_o, acc_o
  );

  modport master (
    output v_i, a_i, b_i, op_i, clear_acc_i, yumi_i,
    input  ready_o, v_o, result_o, flag_overflow_o, flag_zero_o, flag_negative_o, acc_o
  );
endinterface

// File: rtl/valu_mac_lane.sv
// Two-stage valid/ready vector-lane ALU: ADD/SUB/MUL/MAC with a lane-private accumulator.
// Optional VALU_MAC_SATURATE_EN clamps overflowing results instead of wrapping.
module valu_mac_lane #(
  parameter int vdw_p      = 32,
  parameter int op_width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  valu_mac_lane_if.slave     lane
);

  localparam logic [op_width_p-1:0] OP_ADD = op_width_p'(0);
  localparam logic [op_width_p-1:0] OP_SUB = op_width_p'(1);
  localparam logic [op_width_p-1:0] OP_MUL = op_width_p'(2);
  localparam logic [vdw_p:0]        ONE_W  = (vdw_p+1)'(1);

  typedef struct packed {
    logic [vdw_p-1:0]      a;
    logic [vdw_p-1:0]      b;
    logic [op_width_p-1:0] op;
    logic [2*vdw_p-1:0]    prod;
  } s1_t;

  typedef struct packed {
    logic [vdw_p-1:0] result;
    logic             ovf;
    logic             zero;
    logic             neg;
  } s2_t;

  logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [vdw_p-1:0] acc_q, acc_d;

  logic             s2_adv, accept, is_mac;
  logic [vdw_p-1:0] base, prod_lo, r;
  logic             prod_hi_nz, ovf;
  logic [vdw_p:0]   sum_w;

  // S2 frees up when empty or its result is being taken this cycle.
  assign s2_adv       = s1_v_q & (~s2_v_q | lane.yumi_i);
  assign lane.ready_o = ~s1_v_q | s2_adv;
  assign accept       = lane.v_i & lane.ready_o;

  assign s1_v_d = accept | (s1_v_q & ~s2_adv);
  assign s2_v_d = s2_adv | (s2_v_q & ~lane.yumi_i);

  always_comb begin
    s1_d.a    = lane.a_i;
    s1_d.b    = lane.b_i;
    s1_d.op   = lane.op_i;
    s1_d.prod = (2*vdw_p)'(lane.a_i) * (2*vdw_p)'(lane.b_i);
  end

  always_comb begin
    base       = lane.clear_acc_i ? '0 : acc_q;
    prod_lo    = s1_q.prod[vdw_p-1:0];
    prod_hi_nz = |s1_q.prod[2*vdw_p-1:vdw_p];
    is_mac     = 1'b0;
    sum_w      = '0;
    r          = '0;
    ovf        = 1'b0;
    case (s1_q.op)
      OP_ADD: begin
        sum_w = {1'b0, s1_q.a} + {1'b0, s1_q.b};
        r     = sum_w[vdw_p-1:0];
        ovf   = sum_w[vdw_p];
      end
      OP_SUB: begin
        // Borrow is the inverted carry of a + ~b + 1.
        sum_w = {1'b0, s1_q.a} + {1'b0, ~s1_q.b} + ONE_W;
        r     = sum_w[vdw_p-1:0];
        ovf   = ~sum_w[vdw_p];
      end
      OP_MUL: begin
        r   = prod_lo;
        ovf = prod_hi_nz;
      end
      default: begin
        is_mac = 1'b1;
        sum_w  = {1'b0, base} + {1'b0, prod_lo};
        r      = sum_w[vdw_p-1:0];
        ovf    = sum_w[vdw_p] | prod_hi_nz;
      end
    endcase
`ifdef VALU_MAC_SATURATE_EN
    if (ovf) r = (s1_q.op == OP_SUB) ? '0 : '1;
`endif
    s2_d.result = r;
    s2_d.ovf    = ovf;
    s2_d.zero   = (r == '0);
    s2_d.neg    = r[vdw_p-1];
  end

  // A MAC advancing already folded any clear into its base.
  always_comb begin
    acc_d = acc_q;
    if (s2_adv && is_mac)    acc_d = r;
    else if (lane.clear_acc_i) acc_d = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      acc_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      acc_q  <= acc_d;
      if (accept) s1_q <= s1_d;
      if (s2_adv) s2_q <= s2_d;
    end
  end

  assign lane.v_o             = s2_v_q;
  assign lane.result_o        = s2_q.result;
  assign lane.flag_overflow_o = s2_q.ovf;
  assign lane.flag_zero_o     = s2_q.zero;
  assign lane.flag_negative_o = s2_q.neg;
  assign lane.acc_o           = acc_q;

endmodule

// File: tb/tb_valu_mac_lane.sv
// Directed + scoreboard bench for valu_mac_lane (32-bit lane).
module tb_valu_mac_lane;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, MAC = 2'd3;

  typedef struct {
    logic [31:0] r;
    logic        ovf;
    logic        z;
    logic        n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic yumi_en = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  logic [31:0] m_acc = '0;

  always #5 clk = ~clk;

  valu_mac_lane_if #(.vdw_p(32), .op_width_p(2)) lane ();
  assign lane.yumi_i = lane.v_o & yumi_en;

  valu_mac_lane #(.vdw_p(32), .op_width_p(2)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .lane    (lane)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic; the accumulator model advances in issue order.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic clr);
    exp_t        e;
    logic [63:0] p;
    logic [32:0] s;
    logic [31:0] base;
    p = 64'(a) * 64'(b);
    e.r = '0; e.ovf = 1'b0;
    case (op)
      ADD: begin s = 33'(a) + 33'(b); e.r = s[31:0]; e.ovf = s[32]; end
      SUB: begin e.r = a - b; e.ovf = (a < b); end
      MUL: begin e.r = p[31:0]; e.ovf = (p[63:32] != 0); end
      default: begin
        base = clr ? 32'd0 : m_acc;
        s = 33'(base) + 33'(p[31:0]);
        e.r = s[31:0];
        e.ovf = s[32] | (p[63:32] != 0);
      end
    endcase
`ifdef VALU_MAC_SATURATE_EN
    if (e.ovf) e.r = (op == SUB) ? 32'd0 : 32'hFFFF_FFFF;
`endif
    if (op == MAC) m_acc = e.r;
    e.z = (e.r == 0);
    e.n = e.r[31];
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && lane.v_o && lane.yumi_i) begin
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", lane.result_o, e.r);
        chk("ovf", lane.flag_overflow_o, e.ovf);
        chk("zero", lane.flag_zero_o, e.z);
        chk("neg", lane.flag_negative_o, e.n);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic clr = 1'b0);
    logic took = 1'b0;
    int   n = 0;
    lane.v_i = 1'b1; lane.op_i = op; lane.a_i = a; lane.b_i = b;
    while (!took && n < 50) begin
      @(negedge clk); took = lane.ready_o;
      @(posedge clk); #1; n++;
    end
    lane.v_i = 1'b0;
    chk("accept_timeout", took, 1);
    if (took) q.push_back(model(op, a, b, clr));
    if (clr) begin
      lane.clear_acc_i = 1'b1;
      @(posedge clk); #1;
      lane.clear_acc_i = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("drain", q.size(), 0);
  endtask

  task automatic clear_pulse();
    lane.clear_acc_i = 1'b1;
    @(posedge clk); #1;
    lane.clear_acc_i = 1'b0;
    m_acc = '0;
  endtask

  initial begin
    logic [31:0] held;
    lane.v_i = 1'b0; lane.a_i = '0; lane.b_i = '0; lane.op_i = ADD; lane.clear_acc_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_v_o", lane.v_o, 0);
    chk("rst_acc", lane.acc_o, 0);
    chk("rst_result", lane.result_o, 0);
    chk("rst_flags", {lane.flag_overflow_o, lane.flag_zero_o, lane.flag_negative_o}, 0);
    rst = 1'b0;
    #1 chk("rst_ready", lane.ready_o, 1);

    // ADD carry-out and SUB borrow
    send(ADD, 32'hFFFF_FFFF, 32'd1);
    send(SUB, 32'd3, 32'd5);
    send(SUB, 32'd5, 32'd3);
    drain();

    // MAC chain after a clear, then with the clear landing on the 2nd MAC
    clear_pulse();
    chk("acc_cleared", lane.acc_o, 0);
    send(MAC, 32'd2, 32'd3);
    send(MAC, 32'd4, 32'd5);
    drain();
    chk("acc_26", lane.acc_o, 26);
    clear_pulse();
    send(MAC, 32'd2, 32'd3);
    send(MAC, 32'd4, 32'd5, 1'b1);
    drain();
    chk("acc_20", lane.acc_o, 20);

    // MUL high-half overflow, plain MUL, MAC overflow
    send(MUL, 32'h0001_0000, 32'h0001_0000);
    send(MUL, 32'd7, 32'd6);
    send(MAC, 32'hFFFF_FFFF, 32'd2);
    drain();
    chk("acc_after_ovf_mac", lane.acc_o, m_acc);

    for (int i = 0; i < 8; i++)
      send(2'($urandom_range(0, 3)), $urandom, (i % 2 == 0) ? 32'($urandom_range(0, 15)) : $urandom);
    drain();

    // Consumer stall: two accepts fill the pipe, then backpressure
    yumi_en = 1'b0;
    send(ADD, 32'd1, 32'd1);
    send(ADD, 32'd2, 32'd2);
    chk("stall_ready", lane.ready_o, 0);
    chk("stall_v_o", lane.v_o, 1);
    held = lane.result_o;
    chk("stall_head", held, 2);
    lane.v_i = 1'b1; lane.op_i = ADD; lane.a_i = 32'd3; lane.b_i = 32'd3;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("stall_ready_hold", lane.ready_o, 0);
      chk("stall_v_hold", lane.v_o, 1);
      chk("stall_data_hold", lane.result_o, held);
    end
    yumi_en = 1'b1;
    send(ADD, 32'd3, 32'd3);
    send(ADD, 32'd4, 32'd4);
    drain();

    // Reset with two ops in flight
    clear_pulse();
    send(MAC, 32'd3, 32'd3);
    drain();
    chk("acc_9", lane.acc_o, 9);
    send(ADD, 32'd1, 32'd2);
    send(ADD, 32'd3, 32'd4);
    rst = 1'b1;
    #1;
    chk("midrst_v_o", lane.v_o, 0);
    chk("midrst_acc", lane.acc_o, 0);
    q.delete();
    m_acc = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("rel_ready", lane.ready_o, 1);
    lane.v_i = 1'b1; lane.op_i = ADD; lane.a_i = 32'd5; lane.b_i = 32'd6;
    q.push_back(model(ADD, 32'd5, 32'd6, 1'b0));
    @(posedge clk); #1;
    lane.v_i = 1'b0;
    chk("lat_edge1", lane.v_o, 0);
    @(posedge clk); #1;
    chk("lat_edge2", lane.v_o, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
